xif_offload_tracker: RTL and testbench
======================================

# xif_offload_tracker

Parametrised CORE-V-XIF offload tracker between the CPU-side XIF ports of the core wrapper and a coprocessor. It adapts the 3-port register-source issue bus to 2 or 3 coprocessor ports and keeps a scoreboard of up to `DEPTH` outstanding offloaded instructions. It enforces the commit/kill protocol and forwards results only for committed instructions, optionally through a result skid buffer.

## Interface
- `X_NUM_RS`, 3, coprocessor register-source ports; legal values are 2 or 3.
- `X_ID_WIDTH`, 4, instruction ID width.
- `X_RFR_WIDTH`, 32, register read/write data width.
- `DEPTH`, 4, maximum outstanding instructions (≥1).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `cpu_issue_valid_i`/`cpu_issue_ready_o`  in/out  1  core issue handshake.
- `cpu_issue_instr_i`  in  32  instruction.
- `cpu_issue_id_i`  in  X_ID_WIDTH  ID.
- `cpu_issue_rs_i`  in  3*X_RFR_WIDTH  sources.
- `cpu_issue_rs_valid_i`  in  3  source valid bits.
- `cpu_issue_accept_o`, `cpu_issue_writeback_o`  out  1  issue response.
- `cop_issue_valid_o`/`cop_issue_ready_i`  out/in  1  coprocessor issue handshake.
- `cop_issue_instr_o`  out  32.
- `cop_issue_id_o`  out  X_ID_WIDTH.
- `cop_issue_rs_o`  out  X_NUM_RS*X_RFR_WIDTH.
- `cop_issue_rs_valid_o`  out  X_NUM_RS.
- `cop_issue_accept_i`, `cop_issue_writeback_i`  in  1.
- `cpu_commit_valid_i`, `cpu_commit_kill_i`  in  1.
- `cpu_commit_id_i`  in  X_ID_WIDTH.
- `cop_commit_valid_o`, `cop_commit_kill_o`  out  1.
- `cop_commit_id_o`  out  X_ID_WIDTH.
- `cop_result_valid_i`/`cop_result_ready_o`  in/out  1.
- `cop_result_id_i`  in  X_ID_WIDTH.
- `cop_result_data_i`  in  X_RFR_WIDTH.
- `cop_result_rd_i`  in  5.
- `cpu_result_valid_o`/`cpu_result_ready_i`  out/in  1.
- `cpu_result_id_o`  out  X_ID_WIDTH.
- `cpu_result_data_o`  out  X_RFR_WIDTH.
- `cpu_result_rd_o`  out  5.
- `outstanding_o`  out  $clog2(DEPTH+1)  number of non-FREE entries.
- `err_o`  out  1  sticky protocol error.

## Operation
- Each scoreboard entry holds {state, id}. States are FREE, ISSUED and COMMITTED. Reset sets every entry to FREE.
- Issue stalls when the scoreboard is full, or when `cpu_issue_id_i` matches a non-FREE entry:
  - `cop_issue_valid_o` = `cpu_issue_valid_i` & !stall.
  - `cpu_issue_ready_o` = `cop_issue_ready_i` & !stall.
- RS adaptation: with X_NUM_RS=2, the tracker forwards rs[1:0] and rs_valid[1:0]. If `cpu_issue_rs_valid_i[2]` is set, it forces accept=0 to the CPU and sets `err_o`.
- On an issue handshake with accept=1 and writeback=1, the tracker allocates the lowest-index FREE entry as ISSUED. Accept=1 with writeback=0 allocates nothing. Accept=0 allocates nothing.
- Commit passes through unchanged, combinationally. A commit whose ID matches an ISSUED entry has these effects:
  - with kill=1, the entry becomes FREE;
  - with kill=0, the entry becomes COMMITTED.
- A commit that matches no entry is forwarded and has no scoreboard effect.
- Results:
  - `cop_result_ready_o` is high only when the result ID matches a COMMITTED entry and the downstream stage can accept.
  - A result for an ISSUED (uncommitted) ID is held back with ready=0 until its commit arrives.
  - A result whose ID matches no entry is consumed (ready=1), dropped, and sets `err_o`.
  - A result handshake frees its entry.
- Simultaneous events are allowed in the same cycle: allocate, commit and free on different entries. Full/stall is computed from registered state only, so a slot freed this cycle becomes usable next cycle.
- `err_o` is cleared only by reset.

## Timing
- Reset values:
  - all `*_valid_o` = 0;
  - `cpu_issue_accept_o` = 0, `cpu_issue_writeback_o` = 0;
  - `outstanding_o` = 0, `err_o` = 0;
  - skid buffer empty;
  - `cpu_issue_ready_o` follows `cop_issue_ready_i`.
- Issue and commit paths have 0-cycle latency. Scoreboard updates are visible the cycle after the handshake.
- A valid output, once asserted, holds with stable payload until ready.
- Reset mid-operation drops all entries and any buffered result.

## Configuration
- `XIF_RESULT_SKID_EN` defined: the result path goes through a 2-entry skid buffer.
  - 1-cycle latency, full throughput.
  - `cop_result_ready_o` depends only on buffer state and the scoreboard, not on `cpu_result_ready_i`.
- `XIF_RESULT_SKID_EN` undefined: the result path is combinational with 0 latency, and `cop_result_ready_o` includes `cpu_result_ready_i`.

## Test plan
- Basic offload, DEPTH=4:
  - issue id=3 with accept=1, writeback=1 → `outstanding_o`=1;
  - commit id=3 kill=0, then result id=3 data=0xDEADBEEF → CPU receives 0xDEADBEEF (1 cycle later with skid) and `outstanding_o` returns to 0.
- Full: 4 accepted issues (ids 0-3) without commit → 5th `cpu_issue_ready_o`=0. Commit id=0 kill=1 → 5th issue is accepted the following cycle.
- Early result: result id=2 presented before its commit → `cop_result_ready_o`=0. Commit id=2 → ready=1 in the same cycle.
- Unknown result id=9 → consumed and dropped, `err_o`=1 held until `rst_i`.
- X_NUM_RS=2: issue with rs_valid=3'b111 → `cpu_issue_accept_o`=0 and `err_o`=1; rs_valid=3'b011 → rs[1:0] forwarded exactly.
- Backpressure: `cpu_result_ready_i` low for 5 cycles with two committed results → no loss, in-order delivery, stable payload; then `rst_i` mid-stream → all valids 0 next cycle.

Source files
------------

// File: rtl/xif_offload_tracker.sv
// CORE-V-XIF offload tracker: adapts the CPU issue bus to the coprocessor, scoreboards outstanding
// offloads and gates results on commit. Define XIF_RESULT_SKID_EN to register the result path.
module xif_offload_tracker #(
   parameter int X_NUM_RS    = 3,
   parameter int X_ID_WIDTH  = 4,
   parameter int X_RFR_WIDTH = 32,
   parameter int DEPTH       = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            cpu_issue_valid_i,
   output logic                            cpu_issue_ready_o,
   input  logic [31:0]                     cpu_issue_instr_i,
   input  logic [X_ID_WIDTH-1:0]           cpu_issue_id_i,
   input  logic [3*X_RFR_WIDTH-1:0]        cpu_issue_rs_i,
   input  logic [2:0]                      cpu_issue_rs_valid_i,
   output logic                            cpu_issue_accept_o,
   output logic                            cpu_issue_writeback_o,
   output logic                            cop_issue_valid_o,
   input  logic                            cop_issue_ready_i,
   output logic [31:0]                     cop_issue_instr_o,
   output logic [X_ID_WIDTH-1:0]           cop_issue_id_o,
   output logic [X_NUM_RS*X_RFR_WIDTH-1:0] cop_issue_rs_o,
   output logic [X_NUM_RS-1:0]             cop_issue_rs_valid_o,
   input  logic                            cop_issue_accept_i,
   input  logic                            cop_issue_writeback_i,
   input  logic                            cpu_commit_valid_i,
   input  logic                            cpu_commit_kill_i,
   input  logic [X_ID_WIDTH-1:0]           cpu_commit_id_i,
   output logic                            cop_commit_valid_o,
   output logic                            cop_commit_kill_o,
   output logic [X_ID_WIDTH-1:0]           cop_commit_id_o,
   input  logic                            cop_result_valid_i,
   output logic                            cop_result_ready_o,
   input  logic [X_ID_WIDTH-1:0]           cop_result_id_i,
   input  logic [X_RFR_WIDTH-1:0]          cop_result_data_i,
   input  logic [4:0]                      cop_result_rd_i,
   output logic                            cpu_result_valid_o,
   input  logic                            cpu_result_ready_i,
   output logic [X_ID_WIDTH-1:0]           cpu_result_id_o,
   output logic [X_RFR_WIDTH-1:0]          cpu_result_data_o,
   output logic [4:0]                      cpu_result_rd_o,
   output logic [$clog2(DEPTH+1)-1:0]      outstanding_o,
   output logic                            err_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {FREE, ISSUED, COMMITTED} slot_state_e;

   slot_state_e             state_q   [DEPTH];
   slot_state_e             eff_state [DEPTH];
   logic [X_ID_WIDTH-1:0]   id_q      [DEPTH];

   logic             full, issue_hit, free_found, stall, rs_err;
   logic [IDX_W-1:0] alloc_idx, res_idx;
   logic             res_hit, res_committed;
   logic             issue_hs, alloc, down_ready, res_hs, res_fwd, res_drop;
   logic             err_q;
   logic [CNT_W-1:0] busy_cnt;

   // eff_state is the scoreboard with this cycle's commit applied, so a held result can
   // go out in the same cycle as its commit.
   always_comb begin
      // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
      full          = 1'b1;
      issue_hit     = 1'b0;
      free_found    = 1'b0;
      alloc_idx     = '0;
      res_hit       = 1'b0;
      res_committed = 1'b0;
      res_idx       = '0;
      busy_cnt      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         eff_state[i] = state_q[i];
         if (state_q[i] == FREE) begin
            full = 1'b0;
            if (!free_found) begin
               free_found = 1'b1;
               alloc_idx  = IDX_W'(i);
            end
         end else begin
            busy_cnt = busy_cnt + CNT_W'(1);
            if (id_q[i] == cpu_issue_id_i) issue_hit = 1'b1;
         end
         if (cpu_commit_valid_i && state_q[i] == ISSUED && id_q[i] == cpu_commit_id_i)
            eff_state[i] = cpu_commit_kill_i ? FREE : COMMITTED;
         if (eff_state[i] != FREE && id_q[i] == cop_result_id_i) begin
            res_hit       = 1'b1;
            res_committed = (eff_state[i] == COMMITTED);
            res_idx       = IDX_W'(i);
         end
      end
   end

   assign stall  = full | issue_hit;
   assign rs_err = (X_NUM_RS == 2) && cpu_issue_rs_valid_i[2];

   assign cop_issue_valid_o     = cpu_issue_valid_i & ~stall;
   assign cpu_issue_ready_o     = cop_issue_ready_i & ~stall;
   assign cop_issue_instr_o     = cpu_issue_instr_i;
   assign cop_issue_id_o        = cpu_issue_id_i;
   assign cop_issue_rs_o        = cpu_issue_rs_i[X_NUM_RS*X_RFR_WIDTH-1:0];
   assign cop_issue_rs_valid_o  = cpu_issue_rs_valid_i[X_NUM_RS-1:0];
   assign cpu_issue_accept_o    = cop_issue_valid_o & cop_issue_accept_i & ~rs_err;
   assign cpu_issue_writeback_o = cop_issue_valid_o & cop_issue_writeback_i;

   assign issue_hs = cop_issue_valid_o & cop_issue_ready_i;
   assign alloc    = issue_hs & cpu_issue_accept_o & cop_issue_writeback_i;

   assign cop_commit_valid_o = cpu_commit_valid_i;
   assign cop_commit_kill_o  = cpu_commit_kill_i;
   assign cop_commit_id_o    = cpu_commit_id_i;

   // Unknown IDs are swallowed; uncommitted ones wait; committed ones wait for downstream room.
   assign cop_result_ready_o = res_hit ? (res_committed & down_ready) : 1'b1;
   assign res_hs   = cop_result_valid_i & cop_result_ready_o;
   assign res_fwd  = res_hs & res_hit;
   assign res_drop = res_hs & ~res_hit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= eff_state[i];
            if (res_fwd && res_idx == IDX_W'(i)) state_q[i] <= FREE;
            if (alloc && alloc_idx == IDX_W'(i)) state_q[i] <= ISSUED;
         end
         if (res_drop || (issue_hs && rs_err)) err_q <= 1'b1;
      end
   end

   // NOTE: the ID storage has no reset; a FREE state already marks its contents as meaningless.
   always_ff @(posedge clk_i) begin
      if (alloc) id_q[alloc_idx] <= cpu_issue_id_i;
   end

   assign outstanding_o = busy_cnt;
   assign err_o         = err_q;

`ifdef XIF_RESULT_SKID_EN
   logic [1:0]             sk_cnt;
   logic                   sk_wr, sk_rd, sk_pop;
   logic [X_RFR_WIDTH-1:0] sk_data [2];
   logic [X_ID_WIDTH-1:0]  sk_id   [2];
   logic [4:0]             sk_dest [2];

   assign down_ready         = (sk_cnt != 2'd2);
   assign cpu_result_valid_o = (sk_cnt != 2'd0);
   assign cpu_result_id_o    = sk_id[sk_rd];
   assign cpu_result_data_o  = sk_data[sk_rd];
   assign cpu_result_rd_o    = sk_dest[sk_rd];
   assign sk_pop             = cpu_result_valid_o & cpu_result_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sk_cnt <= 2'd0;
         sk_wr  <= 1'b0;
         sk_rd  <= 1'b0;
      end else begin
         if (res_fwd) sk_wr <= ~sk_wr;
         if (sk_pop)  sk_rd <= ~sk_rd;
         case ({res_fwd, sk_pop})
            2'b10:   sk_cnt <= sk_cnt + 2'd1;
            2'b01:   sk_cnt <= sk_cnt - 2'd1;
            default: sk_cnt <= sk_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (res_fwd) begin
         sk_data[sk_wr] <= cop_result_data_i;
         sk_id[sk_wr]   <= cop_result_id_i;
         sk_dest[sk_wr] <= cop_result_rd_i;
      end
   end
`else
   assign down_ready         = cpu_result_ready_i;
   assign cpu_result_valid_o = cop_result_valid_i & res_hit & res_committed;
   assign cpu_result_id_o    = cop_result_id_i;
   assign cpu_result_data_o  = cop_result_data_i;
   assign cpu_result_rd_o    = cop_result_rd_i;
`endif

endmodule

// File: tb/tb_xif_offload_tracker.sv
// Self-checking bench for xif_offload_tracker (default build, combinational result path):
// directed scenarios plus randomized traffic against an ID-keyed reference model.
module tb_xif_offload_tracker;

   localparam int IW = 4;
   localparam int RW = 32;
   localparam int D  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          iv, cop_ir, acc, wb, cv, ck, rv, cpu_rr;
   logic [31:0]   instr;
   logic [IW-1:0] iid, cid, rid;
   logic [3*RW-1:0] rs;
   logic [2:0]    rsv;
   logic [RW-1:0] rdata;
   logic [4:0]    rrd;

   logic          cpu_ir, cpu_acc, cpu_wb, cop_iv, cop_cv, cop_ck, cop_rr, cpu_rv, err;
   logic [31:0]   cop_instr;
   logic [IW-1:0] cop_iid, cop_cid, cpu_rid;
   logic [3*RW-1:0] cop_rs;
   logic [2:0]    cop_rsv, outst;
   logic [RW-1:0] cpu_rdata;
   logic [4:0]    cpu_rrd;

   logic          b_ir, b_acc, b_wb, b_iv, b_cv, b_ck, b_rr, b_rv, b_err;
   logic [31:0]   b_instr;
   logic [IW-1:0] b_iid, b_cid, b_rid;
   logic [2*RW-1:0] b_rs;
   logic [1:0]    b_rsv;
   logic [2:0]    b_outst;
   logic [RW-1:0] b_rdata;
   logic [4:0]    b_rrd;

   int vec  = 0;
   int miss = 0;

   xif_offload_tracker #(.X_NUM_RS(3), .X_ID_WIDTH(IW), .X_RFR_WIDTH(RW), .DEPTH(D)) dut (
      .clk_i(clk), .rst_i(rst),
      .cpu_issue_valid_i(iv), .cpu_issue_ready_o(cpu_ir), .cpu_issue_instr_i(instr),
      .cpu_issue_id_i(iid), .cpu_issue_rs_i(rs), .cpu_issue_rs_valid_i(rsv),
      .cpu_issue_accept_o(cpu_acc), .cpu_issue_writeback_o(cpu_wb),
      .cop_issue_valid_o(cop_iv), .cop_issue_ready_i(cop_ir), .cop_issue_instr_o(cop_instr),
      .cop_issue_id_o(cop_iid), .cop_issue_rs_o(cop_rs), .cop_issue_rs_valid_o(cop_rsv),
      .cop_issue_accept_i(acc), .cop_issue_writeback_i(wb),
      .cpu_commit_valid_i(cv), .cpu_commit_kill_i(ck), .cpu_commit_id_i(cid),
      .cop_commit_valid_o(cop_cv), .cop_commit_kill_o(cop_ck), .cop_commit_id_o(cop_cid),
      .cop_result_valid_i(rv), .cop_result_ready_o(cop_rr), .cop_result_id_i(rid),
      .cop_result_data_i(rdata), .cop_result_rd_i(rrd),
      .cpu_result_valid_o(cpu_rv), .cpu_result_ready_i(cpu_rr), .cpu_result_id_o(cpu_rid),
      .cpu_result_data_o(cpu_rdata), .cpu_result_rd_o(cpu_rrd),
      .outstanding_o(outst), .err_o(err)
   );

   xif_offload_tracker #(.X_NUM_RS(2), .X_ID_WIDTH(IW), .X_RFR_WIDTH(RW), .DEPTH(D)) dut2 (
      .clk_i(clk), .rst_i(rst),
      .cpu_issue_valid_i(iv), .cpu_issue_ready_o(b_ir), .cpu_issue_instr_i(instr),
      .cpu_issue_id_i(iid), .cpu_issue_rs_i(rs), .cpu_issue_rs_valid_i(rsv),
      .cpu_issue_accept_o(b_acc), .cpu_issue_writeback_o(b_wb),
      .cop_issue_valid_o(b_iv), .cop_issue_ready_i(cop_ir), .cop_issue_instr_o(b_instr),
      .cop_issue_id_o(b_iid), .cop_issue_rs_o(b_rs), .cop_issue_rs_valid_o(b_rsv),
      .cop_issue_accept_i(acc), .cop_issue_writeback_i(wb),
      .cpu_commit_valid_i(cv), .cpu_commit_kill_i(ck), .cpu_commit_id_i(cid),
      .cop_commit_valid_o(b_cv), .cop_commit_kill_o(b_ck), .cop_commit_id_o(b_cid),
      .cop_result_valid_i(rv), .cop_result_ready_o(b_rr), .cop_result_id_i(rid),
      .cop_result_data_i(rdata), .cop_result_rd_i(rrd),
      .cpu_result_valid_o(b_rv), .cpu_result_ready_i(cpu_rr), .cpu_result_id_o(b_rid),
      .cpu_result_data_o(b_rdata), .cpu_result_rd_o(b_rrd),
      .outstanding_o(b_outst), .err_o(b_err)
   );

   task automatic idle();
      iv = 0; cop_ir = 0; acc = 0; wb = 0; cv = 0; ck = 0; rv = 0; cpu_rr = 0;
      instr = '0; iid = '0; cid = '0; rid = '0; rs = '0; rsv = '0; rdata = '0; rrd = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; idle(); tick(); rst = 0;
   endtask

   task automatic issue(input logic [IW-1:0] id);
      idle(); iv = 1; iid = id; acc = 1; wb = 1; cop_ir = 1; instr = $urandom; tick(); idle();
   endtask

   task automatic commit(input logic [IW-1:0] id, input logic kill);
      idle(); cv = 1; cid = id; ck = kill; tick(); idle();
   endtask

   task automatic test_reset();
      rst = 1; idle(); cop_ir = 1; tick();
      vec++; if (outst !== 3'd0) begin miss++; $display("FAIL reset_outstanding got %0d exp 0", outst); end
      vec++; if (err !== 1'b0) begin miss++; $display("FAIL reset_err got %b exp 0", err); end
      vec++; if ({cpu_rv, cop_iv, cop_cv, cpu_acc, cpu_wb} !== 5'b0) begin miss++;
         $display("FAIL reset_valids got %b exp 00000", {cpu_rv, cop_iv, cop_cv, cpu_acc, cpu_wb}); end
      vec++; if (cpu_ir !== 1'b1) begin miss++; $display("FAIL reset_issue_ready got %b exp 1", cpu_ir); end
      rst = 0; idle();
   endtask

   task automatic test_basic();
      do_reset();
      iv = 1; iid = 3; acc = 1; wb = 1; cop_ir = 1; instr = 32'h0000_1234; #1;
      vec++; if ({cpu_ir, cop_iv, cpu_acc, cpu_wb} !== 4'b1111) begin miss++;
         $display("FAIL basic_issue got %b exp 1111", {cpu_ir, cop_iv, cpu_acc, cpu_wb}); end
      vec++; if (cop_instr !== 32'h0000_1234 || cop_iid !== 4'd3) begin miss++;
         $display("FAIL basic_issue_payload got %h/%0d exp 00001234/3", cop_instr, cop_iid); end
      tick(); idle();
      vec++; if (outst !== 3'd1) begin miss++; $display("FAIL basic_outstanding1 got %0d exp 1", outst); end
      cv = 1; cid = 3; #1;
      vec++; if (cop_cv !== 1'b1 || cop_cid !== 4'd3 || cop_ck !== 1'b0) begin miss++;
         $display("FAIL basic_commit_pass got %b/%0d/%b exp 1/3/0", cop_cv, cop_cid, cop_ck); end
      tick(); idle();
      rv = 1; rid = 3; rdata = 32'hDEAD_BEEF; rrd = 5'd7; cpu_rr = 1; #1;
      vec++; if (cpu_rv !== 1'b1 || cop_rr !== 1'b1) begin miss++;
         $display("FAIL basic_result_hs got %b/%b exp 1/1", cpu_rv, cop_rr); end
      vec++; if (cpu_rdata !== 32'hDEAD_BEEF || cpu_rrd !== 5'd7 || cpu_rid !== 4'd3) begin miss++;
         $display("FAIL basic_result_data got %h/%0d/%0d exp deadbeef/7/3", cpu_rdata, cpu_rrd, cpu_rid); end
      tick(); idle();
      vec++; if (outst !== 3'd0) begin miss++; $display("FAIL basic_outstanding0 got %0d exp 0", outst); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4; i++) issue(IW'(i));
      iv = 1; iid = 4; acc = 1; wb = 1; cop_ir = 1; #1;
      vec++; if (cpu_ir !== 1'b0 || cop_iv !== 1'b0) begin miss++;
         $display("FAIL full_stall got %b/%b exp 0/0", cpu_ir, cop_iv); end
      vec++; if (outst !== 3'd4) begin miss++; $display("FAIL full_outstanding got %0d exp 4", outst); end
      cv = 1; ck = 1; cid = 0; #1;
      vec++; if (cpu_ir !== 1'b0) begin miss++; $display("FAIL full_same_cycle got %b exp 0", cpu_ir); end
      tick(); cv = 0; ck = 0; #1;
      vec++; if (cpu_ir !== 1'b1 || cop_iv !== 1'b1) begin miss++;
         $display("FAIL full_freed got %b/%b exp 1/1", cpu_ir, cop_iv); end
      tick(); idle();
      vec++; if (outst !== 3'd4) begin miss++; $display("FAIL full_refill got %0d exp 4", outst); end
   endtask

   task automatic test_early_result();
      logic [RW-1:0] d;
      do_reset();
      issue(4'd2);
      d = $urandom;
      rv = 1; rid = 2; rdata = d; cpu_rr = 1; #1;
      vec++; if (cop_rr !== 1'b0 || cpu_rv !== 1'b0) begin miss++;
         $display("FAIL early_held got %b/%b exp 0/0", cop_rr, cpu_rv); end
      tick();
      vec++; if (outst !== 3'd1 || err !== 1'b0) begin miss++;
         $display("FAIL early_kept got %0d/%b exp 1/0", outst, err); end
      cv = 1; cid = 2; #1;
      vec++; if (cop_rr !== 1'b1 || cpu_rv !== 1'b1 || cpu_rdata !== d) begin miss++;
         $display("FAIL early_release got %b/%b/%h exp 1/1/%h", cop_rr, cpu_rv, cpu_rdata, d); end
      tick(); idle();
      vec++; if (outst !== 3'd0 || err !== 1'b0) begin miss++;
         $display("FAIL early_done got %0d/%b exp 0/0", outst, err); end
   endtask

   task automatic test_unknown();
      do_reset();
      rv = 1; rid = 9; rdata = $urandom; cpu_rr = 1; #1;
      vec++; if (cop_rr !== 1'b1 || cpu_rv !== 1'b0) begin miss++;
         $display("FAIL unknown_consume got %b/%b exp 1/0", cop_rr, cpu_rv); end
      tick(); idle();
      repeat (3) tick();
      vec++; if (err !== 1'b1) begin miss++; $display("FAIL unknown_err_sticky got %b exp 1", err); end
      do_reset();
      vec++; if (err !== 1'b0) begin miss++; $display("FAIL unknown_err_cleared got %b exp 0", err); end
   endtask

   task automatic test_rs_adapt();
      logic [3*RW-1:0] r;
      logic [2*RW-1:0] lo;
      do_reset();
      r = {$urandom, $urandom, $urandom};
      iv = 1; iid = 1; acc = 1; wb = 1; cop_ir = 1; rsv = 3'b111; rs = r; #1;
      vec++; if (b_acc !== 1'b0 || cpu_acc !== 1'b1) begin miss++;
         $display("FAIL rs2_forced_reject got %b/%b exp 0/1", b_acc, cpu_acc); end
      tick(); idle();
      vec++; if (b_err !== 1'b1 || b_outst !== 3'd0 || outst !== 3'd1) begin miss++;
         $display("FAIL rs2_err got %b/%0d/%0d exp 1/0/1", b_err, b_outst, outst); end
      r = {$urandom, $urandom, $urandom};
      lo = r[2*RW-1:0];
      iv = 1; iid = 5; acc = 1; wb = 1; cop_ir = 1; rsv = 3'b011; rs = r; #1;
      vec++; if (b_rs !== lo || b_rsv !== 2'b11 || b_acc !== 1'b1) begin miss++;
         $display("FAIL rs2_forward got %h/%b/%b exp %h/11/1", b_rs, b_rsv, b_acc, lo); end
      vec++; if (cop_rs !== r || cop_rsv !== 3'b011) begin miss++;
         $display("FAIL rs3_forward got %h/%b exp %h/011", cop_rs, cop_rsv, r); end
      tick(); idle();
   endtask

   task automatic test_back_to_back();
      logic [RW-1:0] d0, d1;
      do_reset();
      issue(4'd6); issue(4'd7); commit(4'd6, 1'b0); commit(4'd7, 1'b0);
      d0 = $urandom; d1 = $urandom;
      rv = 1; rid = 6; rdata = d0; cpu_rr = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         vec++; if (cpu_rv !== 1'b1 || cpu_rdata !== d0 || cpu_rid !== 4'd6 || cop_rr !== 1'b0) begin miss++;
            $display("FAIL bp_hold cycle %0d got %b/%h/%0d/%b exp 1/%h/6/0", c, cpu_rv, cpu_rdata, cpu_rid, cop_rr, d0); end
         tick();
      end
      cpu_rr = 1; #1;
      vec++; if (cop_rr !== 1'b1) begin miss++; $display("FAIL bp_release got %b exp 1", cop_rr); end
      tick();
      rid = 7; rdata = d1; cpu_rr = 0; #1;
      vec++; if (cpu_rv !== 1'b1 || cpu_rdata !== d1 || cpu_rid !== 4'd7 || outst !== 3'd1) begin miss++;
         $display("FAIL bp_second got %b/%h/%0d/%0d exp 1/%h/7/1", cpu_rv, cpu_rdata, cpu_rid, outst, d1); end
      tick();
      rst = 1; tick();
      vec++; if ({cpu_rv, cop_iv, cop_cv} !== 3'b000 || outst !== 3'd0) begin miss++;
         $display("FAIL bp_reset got %b/%0d exp 000/0", {cpu_rv, cop_iv, cop_cv}, outst); end
      rst = 0; idle();
   endtask

   // Reference: per-ID state (0 none, 1 issued, 2 committed), capacity D, sticky error flag.
   task automatic test_random();
      int st [16];
      logic m_err, stall, e_ir, e_iv, e_acc, e_rr, e_rv;
      int cnt, s;
      do_reset();
      foreach (st[k]) st[k] = 0;
      m_err = 0;
      for (int c = 0; c < 400; c++) begin
         iv = 1'($urandom % 2); iid = IW'($urandom % 8); acc = ($urandom % 4) != 0;
         wb = ($urandom % 4) != 0; cop_ir = ($urandom % 4) != 0; rsv = 3'($urandom);
         rs = {$urandom, $urandom, $urandom}; instr = $urandom;
         cv = ($urandom % 3) == 0; ck = ($urandom % 4) == 0; cid = IW'($urandom % 8);
         rv = 1'($urandom % 2); rid = IW'($urandom % 8); rdata = $urandom; rrd = 5'($urandom);
         cpu_rr = ($urandom % 4) != 0;
         cnt = 0;
         foreach (st[k]) if (st[k] != 0) cnt++;
         stall = (cnt == D) || (st[iid] != 0);
         e_ir  = cop_ir && !stall;
         e_iv  = iv && !stall;
         e_acc = e_iv && acc;
         s = st[rid];
         if (cv && cid == rid && s == 1) s = ck ? 0 : 2;
         e_rr = (s == 2) ? cpu_rr : (s == 1) ? 1'b0 : 1'b1;
         e_rv = rv && (s == 2);
         #1;
         vec++; if (cpu_ir !== e_ir || cop_iv !== e_iv || cpu_acc !== e_acc) begin miss++;
            $display("FAIL rnd_issue c%0d got %b%b%b exp %b%b%b", c, cpu_ir, cop_iv, cpu_acc, e_ir, e_iv, e_acc); end
         vec++; if (cop_rr !== e_rr || cpu_rv !== e_rv || (e_rv && cpu_rdata !== rdata)) begin miss++;
            $display("FAIL rnd_result c%0d got %b/%b/%h exp %b/%b/%h", c, cop_rr, cpu_rv, cpu_rdata, e_rr, e_rv, rdata); end
         vec++; if (outst !== 3'(cnt) || err !== m_err) begin miss++;
            $display("FAIL rnd_state c%0d got %0d/%b exp %0d/%b", c, outst, err, cnt, m_err); end
         tick();
         if (cv && st[cid] == 1) st[cid] = ck ? 0 : 2;
         if (rv && e_rr) begin
            if (st[rid] == 2) st[rid] = 0;
            else if (st[rid] == 0) m_err = 1;
         end
         if (iv && e_ir && acc && wb) st[iid] = 1;
      end
      idle();
   endtask

   initial begin
      rst = 1; idle();
      test_reset();
      test_basic();
      test_full();
      test_early_result();
      test_unknown();
      test_rs_adapt();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
